acc_sequencer: RTL and testbench
================================

// Module: acc_sequencer
// PURPOSE
//  Multi-cycle controller that sequences the accumulator and temp registers of the 8-bit datapath.
//  - Accepts one operation per start/busy/done handshake.
//  - Loads the operand into temp, then computes acc <op> temp and writes the result back to acc.
//  - MUL is an iterative shift-add.
//  - Sits between instruction decode and the accumulator/temp pair.
//  - Drives their load and data inputs; reads back their outputs.
// PARAMETERS
//  DATA_W  8  datapath width; acc, temp, operand and result buses are all DATA_W bits.
// PORTS
//  clk        in   1       system clock; all state changes on posedge.
//  reset      in   1       synchronous, active-high reset.
//  start      in   1       request a new op; honoured only in IDLE.
//  opcode     in   3       op select, captured on accept.
//  operand    in   DATA_W  operand from bus/memory, captured on accept.
//  acc_q      in   DATA_W  current accumulator output.
//  temp_q     in   DATA_W  current temp register output.
//  acc_load   out  1       one-cycle write strobe to accumulator.
//  acc_d      out  DATA_W  accumulator write data.
//  temp_load  out  1       one-cycle write strobe to temp.
//  temp_d     out  DATA_W  temp write data (the captured operand).
//  busy       out  1       high from the cycle after accept through DONE.
//  done       out  1       one-cycle completion pulse.
//  flag_z     out  1       result == 0, registered.
//  flag_c     out  1       carry/borrow/overflow, registered.
// BEHAVIOUR
//  - Reset: state = IDLE.
//    - All outputs 0: acc_load, temp_load, busy, done, flag_z, flag_c; acc_d, temp_d = 0.
//    - Captured opcode/operand and MUL registers cleared.
//    - Reset mid-op aborts immediately; no acc or temp write occurs in that cycle.
//  - Opcodes:
//    - 0 LDA: acc = temp.
//    - 1 ADD: acc = acc + temp; C = carry-out.
//    - 2 SUB: acc = acc - temp; C = borrow, i.e. acc < temp unsigned.
//    - 3 AND, 4 OR, 5 XOR: C = 0.
//    - 6 MUL: acc = low DATA_W bits of acc*temp; C = 1 if the high half is nonzero.
//    - 7 CLR: acc = 0; C = 0.
//    - Z = (result == 0) for every opcode.
//  - FSM: IDLE -> LOAD_T -> EXEC -> DONE -> IDLE; for MUL, EXEC is replaced by MUL_RUN.
//    - IDLE: start=1 captures opcode/operand; goes to LOAD_T next cycle.
//    - LOAD_T: temp_load=1, temp_d=operand; goes to EXEC, or to MUL_RUN if opcode==6.
//    - EXEC: temp_q now holds the operand. acc_load=1, acc_d=result; flags register; goes to DONE.
//    - MUL_RUN, entry cycle:
//      - Latches mcand=temp_q, mplier=acc_q, prod=0 (2*DATA_W bits), cnt=0.
//      - Spends exactly DATA_W further step cycles, then goes to DONE.
//    - MUL_RUN, each step:
//      - if mplier[0], prod += mcand << cnt.
//      - mplier >>= 1; cnt++.
//    - MUL_RUN, final step: acc_load=1, acc_d=prod low half (including the last partial product); flags register.
//    - DONE: done=1; busy stays 1; returns to IDLE.
//  - Latency (start-accept cycle = 0):
//    - Non-MUL: temp_load @1, acc_load @2, done @3; next accept possible @4.
//    - MUL: acc_load @(2+DATA_W), done @(3+DATA_W).
//  - Handshake:
//    - start while busy is ignored; it is not queued.
//    - start held high re-accepts in the first IDLE cycle after DONE.
//    - opcode/operand changes after accept have no effect.
//  - Strobes:
//    - acc_load and temp_load are never high in the same cycle; each is high at most once per op.
//    - acc_d/temp_d are 0 whenever their strobe is low.
//  - Flags change only in an acc_load cycle, and hold otherwise.
//  - Arithmetic is unsigned, modulo 2^DATA_W. MUL cnt is sized to reach DATA_W without wrap.
// TESTING
//  - Reset: pulse reset, hold start=1 -> all outputs 0 and state IDLE during reset. First accept occurs on the first cycle after reset deasserts.
//  - ADD wrap: acc=8'hF0, start op1 operand 8'h20 -> temp_load @1 (temp_d=20), acc_load @2 with acc_d=8'h10, C=1, Z=0; done @3.
//  - SUB borrow/zero:
//    - acc=8'h05, SUB 8'h06 -> acc_d=8'hFF, C=1.
//    - then SUB 8'hFF -> acc_d=0, Z=1, C=0.
//  - MUL: acc=8'h0D, MUL 8'h0B -> acc_d=8'h8F, C=0, acc_load @10, done @11.
//    - acc=8'h20, MUL 8'h10 -> acc_d=0, Z=1, C=1.
//  - Busy/abort:
//    - start pulses during busy -> ignored; exactly one done per accepted op.
//    - reset asserted in MUL step 4 -> no acc_load ever; IDLE next cycle.
//  - Back-to-back: start held high across LDA 8'h3C then CLR -> accepts @0 and @4. acc_d=3C @2, acc_d=00 @6 with Z=1.

Source files
------------

// File: rtl/acc_sequencer_if.sv
// Handshake and accumulator/temp register bus between decode, the sequencer
// and the acc/temp register pair.
interface acc_sequencer_if #(
   parameter int DATA_W = 8
);
   logic              start;
   logic [2:0]        opcode;
   logic [DATA_W-1:0] operand;
   logic [DATA_W-1:0] acc_q;
   logic [DATA_W-1:0] temp_q;
   logic              acc_load;
   logic [DATA_W-1:0] acc_d;
   logic              temp_load;
   logic [DATA_W-1:0] temp_d;
   logic              busy;
   logic              done;
   logic              flag_z;
   logic              flag_c;

   modport master (
      output start, opcode, operand, acc_q, temp_q,
      input  acc_load, acc_d, temp_load, temp_d, busy, done, flag_z, flag_c
   );

   modport slave (
      input  start, opcode, operand, acc_q, temp_q,
      output acc_load, acc_d, temp_load, temp_d, busy, done, flag_z, flag_c
   );
endinterface

// File: rtl/acc_sequencer.sv
// Multi-cycle sequencer for the accumulator/temp pair: loads the operand into
// temp, then writes acc <op> temp back to acc; MUL runs as iterative shift-add.
module acc_sequencer #(
   parameter int DATA_W = 8
) (
   input logic             clk,
   input logic             reset,
   acc_sequencer_if.slave  bus
);

   localparam int               CNT_W     = $clog2(DATA_W + 1);
   localparam logic [2:0]       OP_MUL    = 3'd6;
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD_T,
      S_EXEC,
      S_MUL_RUN,
      S_DONE
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [2:0]          r_opcode;
   logic [DATA_W-1:0]   r_operand;
   logic [DATA_W-1:0]   r_mcand;
   logic [DATA_W-1:0]   r_mplier;
   logic [2*DATA_W-1:0] r_prod;
   logic [CNT_W-1:0]    r_cnt;
   logic                r_mul_init;
   logic                r_flag_z;
   logic                r_flag_c;

   logic                w_acc_load;
   logic [DATA_W-1:0]   w_acc_d;
   logic                w_temp_load;
   logic [DATA_W-1:0]   w_temp_d;
   logic                w_busy;
   logic                w_done;
   logic                w_flag_c_nxt;
   logic [2*DATA_W-1:0] w_step_prod;

   // Single-cycle ops; MSB of the return value is the carry/borrow flag.
   function automatic logic [DATA_W:0] alu_result(
      input logic [2:0]        op,
      input logic [DATA_W-1:0] a,
      input logic [DATA_W-1:0] b
   );
      logic [DATA_W:0] r;
      r = '0;
      case (op)
         3'd0:    r = {1'b0, b};
         3'd1:    r = {1'b0, a} + {1'b0, b};
         3'd2:    r = {(a < b), a - b};
         3'd3:    r = {1'b0, a & b};
         3'd4:    r = {1'b0, a | b};
         3'd5:    r = {1'b0, a ^ b};
         default: r = '0;
      endcase
      return r;
   endfunction

   function automatic logic [2*DATA_W-1:0] mul_step(
      input logic [2*DATA_W-1:0] prod,
      input logic [DATA_W-1:0]   mcand,
      input logic                mplier_lsb,
      input logic [CNT_W-1:0]    cnt
   );
      logic [2*DATA_W-1:0] pp;
      pp = mplier_lsb ? ({{DATA_W{1'b0}}, mcand} << cnt) : '0;
      return prod + pp;
   endfunction

   assign w_step_prod = mul_step(r_prod, r_mcand, r_mplier[0], r_cnt);

   always_comb begin
      w_state_nxt  = r_state;
      w_acc_load   = 1'b0;
      w_acc_d      = '0;
      w_temp_load  = 1'b0;
      w_temp_d     = '0;
      w_busy       = 1'b0;
      w_done       = 1'b0;
      w_flag_c_nxt = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bus.start) w_state_nxt = S_LOAD_T;
         end
         S_LOAD_T: begin
            w_busy      = 1'b1;
            w_temp_load = 1'b1;
            w_temp_d    = r_operand;
            w_state_nxt = (r_opcode == OP_MUL) ? S_MUL_RUN : S_EXEC;
         end
         S_EXEC: begin
            w_busy                  = 1'b1;
            {w_flag_c_nxt, w_acc_d} = alu_result(r_opcode, bus.acc_q, bus.temp_q);
            w_acc_load              = 1'b1;
            w_state_nxt             = S_DONE;
         end
         S_MUL_RUN: begin
            w_busy = 1'b1;
            // The last step writes back with its own partial product folded in.
            if (!r_mul_init && (r_cnt == LAST_STEP)) begin
               w_acc_load   = 1'b1;
               w_acc_d      = w_step_prod[DATA_W-1:0];
               w_flag_c_nxt = |w_step_prod[2*DATA_W-1:DATA_W];
               w_state_nxt  = S_DONE;
            end
         end
         S_DONE: begin
            w_busy      = 1'b1;
            w_done      = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
      // Reset aborts in the same cycle: no strobe may escape.
      if (reset) begin
         w_state_nxt  = S_IDLE;
         w_acc_load   = 1'b0;
         w_acc_d      = '0;
         w_temp_load  = 1'b0;
         w_temp_d     = '0;
         w_busy       = 1'b0;
         w_done       = 1'b0;
         w_flag_c_nxt = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_opcode   <= '0;
         r_operand  <= '0;
         r_mcand    <= '0;
         r_mplier   <= '0;
         r_prod     <= '0;
         r_cnt      <= '0;
         r_mul_init <= 1'b0;
         r_flag_z   <= 1'b0;
         r_flag_c   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if ((r_state == S_IDLE) && bus.start) begin
            r_opcode  <= bus.opcode;
            r_operand <= bus.operand;
         end
         if (r_state == S_LOAD_T) r_mul_init <= (r_opcode == OP_MUL);
         if (r_state == S_MUL_RUN) begin
            if (r_mul_init) begin
               r_mcand    <= bus.temp_q;
               r_mplier   <= bus.acc_q;
               r_prod     <= '0;
               r_cnt      <= '0;
               r_mul_init <= 1'b0;
            end else begin
               r_prod   <= w_step_prod;
               r_mplier <= r_mplier >> 1;
               r_cnt    <= r_cnt + CNT_W'(1);
            end
         end
         if (w_acc_load) begin
            r_flag_z <= (w_acc_d == '0);
            r_flag_c <= w_flag_c_nxt;
         end
      end
   end

   assign bus.acc_load  = w_acc_load;
   assign bus.acc_d     = w_acc_d;
   assign bus.temp_load = w_temp_load;
   assign bus.temp_d    = w_temp_d;
   assign bus.busy      = w_busy;
   assign bus.done      = w_done;
   assign bus.flag_z    = r_flag_z & ~reset;
   assign bus.flag_c    = r_flag_c & ~reset;

endmodule

// File: tb/tb_acc_sequencer.sv
// Bench for acc_sequencer: directed scenarios plus random traffic, checked every
// cycle against a latency/arithmetic reference model.
module tb_acc_sequencer;
   localparam int DATA_W = 8;

   logic       clk      = 1'b0;
   logic       reset    = 1'b1;
   int         cyc      = 0;
   int         checks   = 0;
   int         failures = 0;
   logic       set_req  = 1'b0;
   logic [7:0] set_val  = 8'h00;
   logic [7:0] acc_reg  = 8'h00;
   logic [7:0] temp_reg = 8'h00;

   acc_sequencer_if #(.DATA_W(DATA_W)) bus ();

   acc_sequencer #(.DATA_W(DATA_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Accumulator and temp registers the sequencer drives.
   always @(posedge clk) begin
      if (set_req) acc_reg <= set_val;
      else if (bus.acc_load) acc_reg <= bus.acc_d;
      if (bus.temp_load) temp_reg <= bus.temp_d;
   end
   assign bus.acc_q  = acc_reg;
   assign bus.temp_q = temp_reg;

   // Reference model state: ph = cycles since accept (0 = idle), lat = done cycle.
   int         ph    = 0;
   int         lat   = 3;
   logic [7:0] m_acc = 8'h00;
   logic [7:0] m_opd = 8'h00;
   logic [7:0] m_res = 8'h00;
   logic       m_c   = 1'b0;
   logic       f_z   = 1'b0;
   logic       f_c   = 1'b0;

   int         tl_cyc   = -1;
   logic [7:0] tl_dat   = 8'h00;
   int         done_cyc = -1;
   int         done_cnt = 0;
   int         ald_cyc[$];
   logic [7:0] ald_dat[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic model_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                           output logic [7:0] r, output logic c);
      int s;
      r = 8'h00;
      c = 1'b0;
      case (op)
         3'd0: r = b;
         3'd1: begin s = int'(a) + int'(b); r = 8'(s); c = (s > 255); end
         3'd2: begin r = a - b; c = (a < b); end
         3'd3: r = a & b;
         3'd4: r = a | b;
         3'd5: r = a ^ b;
         3'd6: begin s = int'(a) * int'(b); r = 8'(s); c = (s > 255); end
         default: r = 8'h00;
      endcase
   endtask

   // Per-cycle compare, then advance the model by one clock.
   always @(negedge clk) begin
      logic [21:0] e;
      logic [21:0] a;
      logic        etl, eal, edn, ebz;
      logic [7:0]  etd, ead;
      if (cyc >= 1) begin
         etl = 1'b0; etd = 8'h00; eal = 1'b0; ead = 8'h00; edn = 1'b0;
         ebz = (!reset && ph != 0);
         if (ebz) begin
            etl = (ph == 1);
            etd = etl ? m_opd : 8'h00;
            eal = (ph == lat - 1);
            ead = eal ? m_res : 8'h00;
            edn = (ph == lat);
         end
         e = {etl, etd, eal, ead, ebz, edn, f_z & ~reset, f_c & ~reset};
         a = {bus.temp_load, bus.temp_d, bus.acc_load, bus.acc_d,
              bus.busy, bus.done, bus.flag_z, bus.flag_c};
         chk("outputs", 32'(a), 32'(e));

         if (bus.temp_load === 1'b1) begin tl_cyc = cyc; tl_dat = bus.temp_d; end
         if (bus.acc_load === 1'b1) begin ald_cyc.push_back(cyc); ald_dat.push_back(bus.acc_d); end
         if (bus.done === 1'b1) begin done_cyc = cyc; done_cnt++; end

         if (reset) begin
            ph  = 0;
            f_z = 1'b0;
            f_c = 1'b0;
         end else if (ph != 0) begin
            if (ph == lat - 1) begin
               m_acc = m_res;
               f_z   = (m_res == 8'h00);
               f_c   = m_c;
            end
            ph = (ph == lat) ? 0 : ph + 1;
         end else if (bus.start) begin
            m_opd = bus.operand;
            model_op(bus.opcode, m_acc, bus.operand, m_res, m_c);
            lat = (bus.opcode == 3'd6) ? 3 + DATA_W : 3;
            ph  = 1;
         end
         if (set_req) m_acc = set_val;
      end
   end

   task automatic set_acc(input logic [7:0] v);
      @(posedge clk); #1;
      set_req = 1'b1;
      set_val = v;
      @(posedge clk); #1;
      set_req = 1'b0;
   endtask

   task automatic issue(input logic [2:0] op, input logic [7:0] opd, output int c0);
      @(posedge clk); #1;
      bus.start   = 1'b1;
      bus.opcode  = op;
      bus.operand = opd;
      c0          = cyc;
      @(posedge clk); #1;
      bus.start   = 1'b0;
      bus.opcode  = 3'($urandom);
      bus.operand = 8'($urandom);
   endtask

   task automatic wait_done(input string name);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus.done === 1'b1) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) begin
         checks++;
         failures++;
         $display("FAIL %s done not seen within 40 cycles", name);
      end
      #1;
   endtask

   int c0;
   int dc0;

   initial begin
      bus.start   = 1'b1;
      bus.opcode  = 3'd7;
      bus.operand = 8'hAA;
      reset       = 1'b1;

      // Reset with start held: quiet outputs, accept right after release.
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_tload", 32'(bus.temp_load), 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      c0    = cyc;
      @(posedge clk); #1;
      bus.start = 1'b0;
      wait_done("rst_first");
      chk("rst_first_tl", 32'(tl_cyc - c0), 32'd1);
      chk("rst_first_done", 32'(done_cyc - c0), 32'd3);

      // ADD with carry out.
      set_acc(8'hF0);
      issue(3'd1, 8'h20, c0);
      wait_done("add");
      chk("add_tl_lat", 32'(tl_cyc - c0), 32'd1);
      chk("add_temp_d", 32'(tl_dat), 32'h20);
      chk("add_ald_lat", 32'(ald_cyc[ald_cyc.size()-1] - c0), 32'd2);
      chk("add_acc_d", 32'(ald_dat[ald_dat.size()-1]), 32'h10);
      chk("add_done_lat", 32'(done_cyc - c0), 32'd3);
      chk("add_acc", 32'(acc_reg), 32'h10);
      chk("add_model", 32'(m_acc), 32'h10);
      chk("add_c", 32'(bus.flag_c), 32'd1);
      chk("add_z", 32'(bus.flag_z), 32'd0);

      // SUB with borrow, then SUB to zero.
      set_acc(8'h05);
      issue(3'd2, 8'h06, c0);
      wait_done("sub1");
      chk("sub1_acc", 32'(acc_reg), 32'hFF);
      chk("sub1_c", 32'(bus.flag_c), 32'd1);
      issue(3'd2, 8'hFF, c0);
      wait_done("sub2");
      chk("sub2_acc", 32'(acc_reg), 32'h00);
      chk("sub2_z", 32'(bus.flag_z), 32'd1);
      chk("sub2_c", 32'(bus.flag_c), 32'd0);

      // MUL without and with high-half overflow.
      set_acc(8'h0D);
      issue(3'd6, 8'h0B, c0);
      wait_done("mul1");
      chk("mul1_acc", 32'(acc_reg), 32'h8F);
      chk("mul1_model", 32'(m_acc), 32'h8F);
      chk("mul1_c", 32'(bus.flag_c), 32'd0);
      chk("mul1_ald_lat", 32'(ald_cyc[ald_cyc.size()-1] - c0), 32'd10);
      chk("mul1_done_lat", 32'(done_cyc - c0), 32'd11);
      set_acc(8'h20);
      issue(3'd6, 8'h10, c0);
      wait_done("mul2");
      chk("mul2_acc", 32'(acc_reg), 32'h00);
      chk("mul2_z", 32'(bus.flag_z), 32'd1);
      chk("mul2_c", 32'(bus.flag_c), 32'd1);

      // start pulses while busy are dropped.
      set_acc(8'h01);
      dc0 = done_cnt;
      issue(3'd1, 8'h02, c0);
      bus.start = 1'b1; bus.opcode = 3'd7;
      @(posedge clk); #1;
      bus.start = 1'b0;
      wait_done("busy_ign");
      repeat (6) @(negedge clk);
      #1;
      chk("busy_ign_acc", 32'(acc_reg), 32'h03);
      chk("busy_ign_dones", 32'(done_cnt - dc0), 32'd1);

      // Reset during MUL step 4 aborts without an acc write.
      set_acc(8'h55);
      issue(3'd6, 8'h03, c0);
      while (cyc < c0 + 6) begin @(posedge clk); #1; end
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      chk("abort_idle", 32'(bus.busy), 32'd0);
      repeat (14) @(negedge clk);
      #1;
      chk("abort_acc", 32'(acc_reg), 32'h55);
      chk("abort_noload", 32'(ald_cyc[ald_cyc.size()-1] >= c0), 32'd0);

      // Back-to-back with start held: LDA 3C then CLR.
      @(posedge clk); #1;
      bus.start = 1'b1; bus.opcode = 3'd0; bus.operand = 8'h3C;
      c0 = cyc;
      @(posedge clk); #1;
      bus.opcode = 3'd7; bus.operand = 8'($urandom);
      while (cyc < c0 + 5) begin @(posedge clk); #1; end
      bus.start = 1'b0;
      wait_done("b2b");
      chk("b2b_ald1_lat", 32'(ald_cyc[ald_cyc.size()-2] - c0), 32'd2);
      chk("b2b_ald1_d", 32'(ald_dat[ald_dat.size()-2]), 32'h3C);
      chk("b2b_ald2_lat", 32'(ald_cyc[ald_cyc.size()-1] - c0), 32'd6);
      chk("b2b_ald2_d", 32'(ald_dat[ald_dat.size()-1]), 32'h00);
      chk("b2b_z", 32'(bus.flag_z), 32'd1);

      // Random traffic, including occasional resets.
      for (int i = 0; i < 2000; i++) begin
         @(posedge clk); #1;
         reset       = ($urandom_range(0, 99) == 0);
         bus.start   = ($urandom_range(0, 2) == 0);
         bus.opcode  = 3'($urandom);
         bus.operand = 8'($urandom);
      end
      @(posedge clk); #1;
      reset     = 1'b0;
      bus.start = 1'b0;
      repeat (20) @(posedge clk);
      @(negedge clk); #1;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog simulation did not finish actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule
